csr_trap_unit: RTL and testbench
================================

// Module: csr_trap_unit
// PURPOSE
// Machine-mode trap CSR file. Generalises the single-register mepc save unit to
// mstatus, mie, mip, mtvec, mepc, mcause and mscratch. Adds interrupt arbitration,
// mret sequencing and a RUN/HANDLER/LOCKUP state machine. Sits beside the core's
// PC logic: the core reports traps and mret; software reaches the CSRs over the
// memory bus.
// PARAMETERS
// DATA_WIDTH        32            CSR and PC width
// NUM_IRQ           4             level interrupt lines, 1..16
// RESET_TRAP_VECTOR 32'h0000_0100 mtvec reset value; bits [1:0] are ignored
// PORTS
// clock            in   1           rising-edge clock
// resetActiveHigh  in   1           asynchronous, active-high reset
// pcFromCore       in   DATA_WIDTH  PC of the instruction being trapped
// exceptionValid   in   1           synchronous exception this cycle
// exceptionCause   in   4           exception code
// mretValid        in   1           mret retiring this cycle
// irqLines         in   NUM_IRQ     level-sensitive interrupt requests
// busAddress       in   3           CSR select
// busWriteEnable   in   1           software write strobe
// busWriteData     in   DATA_WIDTH  software write data
// busReadData      out  DATA_WIDTH  combinational read of the selected CSR
// trapTaken        out  1           combinational; trap accepted this cycle
// trapVector       out  DATA_WIDTH  {mtvec[DW-1:2],2'b00}, core jump target
// mepcValue        out  DATA_WIDTH  current mepc, mret return target
// inHandler        out  1           state == HANDLER
// lockup           out  1           state == LOCKUP
// BEHAVIOUR
// - Address map: 0 mstatus (MIE bit3, MPIE bit7, other bits read 0); 1 mie [NUM_IRQ-1:0];
//   2 mtvec; 3 mepc; 4 mcause; 5 mscratch; 6 mip (read-only = irqLines); 7 reads 0.
//   Writes to 6 and 7 are ignored.
// - Reset: all CSRs = 0 except mtvec = RESET_TRAP_VECTOR. State RUN. trapTaken, inHandler
//   and lockup = 0. Reset asserted mid-handler forces RUN immediately.
// - pending = irqLines & mie. irqTake = RUN & MIE & |pending & !exceptionValid.
//   The lowest-index pending line wins.
// - RUN + exceptionValid, or irqTake: trapTaken=1 in the same cycle. At the next edge:
//   mepc<=pcFromCore; MPIE<=MIE; MIE<=0; state->HANDLER.
//   Exception: mcause<={0,exceptionCause}. IRQ: mcause<={1,index}, MSB = bit DW-1.
// - Exceptions take priority over interrupts. An exception is taken even when MIE=0.
// - HANDLER + exceptionValid (double fault): trapTaken=0 and state->LOCKUP; no CSR update.
//   LOCKUP is left only by reset. In LOCKUP, trap and mret inputs are ignored; bus
//   reads and writes still work.
// - Interrupts are taken only in RUN, even if software sets MIE inside the handler.
// - HANDLER + mretValid (no exception): MIE<=MPIE; MPIE<=1; state->RUN at the next edge.
//   mret in RUN is ignored. Exception together with mret: the exception wins.
// - Bus write to register X in the same cycle as a hardware update of X: the bus value
//   wins for X only. Other hardware updates still occur; e.g. a mepc write during a trap
//   still updates mcause, MIE, MPIE and state.
// - All CSR updates are visible on busReadData and mepcValue the cycle after the edge.
// TESTING
// - Reset: mtvec reads 0x100; other CSRs read 0; trapTaken/inHandler/lockup = 0.
// - exceptionValid=1, cause=2, pc=0x40 in RUN -> trapTaken=1 and trapVector=0x100;
//   next cycle mepc=0x40, mcause=0x2, MIE=0, inHandler=1.
// - MIE=1, mie=0xF, irqLines=0b1100 -> mcause=0x8000_0002. A following mret restores
//   MIE=1, MPIE=1 and state RUN.
// - Same cycle: bus write mepc=0x200 and an exception with pc=0x40 -> mepc=0x200 and
//   mcause updated.
// - Exception in HANDLER -> lockup=1 and held; a later mret has no effect; reset clears it.
// - MIE=0 with irqLines and mie both 0xF -> no trap; mip reads 0xF; a write to mip is ignored.

Source files
------------

// File: rtl/csr_trap_unit.sv
// ---------------------------------------------------------------------------
// csr_trap_unit
//
// Machine-mode trap CSR file: mstatus (MIE/MPIE), mie, mip, mtvec, mepc,
// mcause and mscratch. It arbitrates synchronous exceptions against level
// interrupts, sequences trap entry and mret, and tracks a RUN / HANDLER /
// LOCKUP state machine. The core reports traps and mret. Software reaches
// the CSRs through a small memory-mapped bus.
//
// Ports
//   clock            in   1           rising-edge clock
//   resetActiveHigh  in   1           asynchronous, active-high reset
//   pcFromCore       in   DATA_WIDTH  PC of the instruction being trapped
//   exceptionValid   in   1           synchronous exception this cycle
//   exceptionCause   in   4           exception code
//   mretValid        in   1           mret retiring this cycle
//   irqLines         in   NUM_IRQ     level-sensitive interrupt requests
//   busAddress       in   3           CSR select
//   busWriteEnable   in   1           software write strobe
//   busWriteData     in   DATA_WIDTH  software write data
//   busReadData      out  DATA_WIDTH  combinational read of the selected CSR
//   trapTaken        out  1           trap accepted this cycle (combinational)
//   trapVector       out  DATA_WIDTH  {mtvec[DW-1:2],2'b00}, core jump target
//   mepcValue        out  DATA_WIDTH  current mepc, mret return target
//   inHandler        out  1           state == HANDLER
//   lockup           out  1           state == LOCKUP
// ---------------------------------------------------------------------------
module csr_trap_unit #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    NUM_IRQ           = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                  clock,
    input  logic                  resetActiveHigh,
    input  logic [DATA_WIDTH-1:0] pcFromCore,
    input  logic                  exceptionValid,
    input  logic [3:0]            exceptionCause,
    input  logic                  mretValid,
    input  logic [NUM_IRQ-1:0]    irqLines,
    input  logic [2:0]            busAddress,
    input  logic                  busWriteEnable,
    input  logic [DATA_WIDTH-1:0] busWriteData,
    output logic [DATA_WIDTH-1:0] busReadData,
    output logic                  trapTaken,
    output logic [DATA_WIDTH-1:0] trapVector,
    output logic [DATA_WIDTH-1:0] mepcValue,
    output logic                  inHandler,
    output logic                  lockup
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_LOCKUP  = 2'd2
    } state_t;

    // CSR bus addresses
    localparam logic [2:0] ADDR_MSTATUS  = 3'd0;
    localparam logic [2:0] ADDR_MIE      = 3'd1;
    localparam logic [2:0] ADDR_MTVEC    = 3'd2;
    localparam logic [2:0] ADDR_MEPC     = 3'd3;
    localparam logic [2:0] ADDR_MCAUSE   = 3'd4;
    localparam logic [2:0] ADDR_MSCRATCH = 3'd5;
    localparam logic [2:0] ADDR_MIP      = 3'd6;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_mstatus_mie;
    logic                    r_mstatus_mpie;
    logic [NUM_IRQ-1:0]      r_mie;
    logic [DATA_WIDTH-1:0]   r_mtvec;
    logic [DATA_WIDTH-1:0]   r_mepc;
    logic [DATA_WIDTH-1:0]   r_mcause;
    logic [DATA_WIDTH-1:0]   r_mscratch;

    logic [NUM_IRQ-1:0]      w_pending;
    logic [3:0]              w_irq_index;
    logic                    w_exc_take;
    logic                    w_irq_take;
    logic                    w_trap;
    logic                    w_mret;
    logic [3:0]              w_cause_code;
    logic [DATA_WIDTH-1:0]   w_new_mcause;
    logic [DATA_WIDTH-1:0]   w_mstatus_rd;
    logic [DATA_WIDTH-1:0]   w_mie_rd;
    logic [DATA_WIDTH-1:0]   w_mip_rd;

    logic                    w_wr_mstatus;
    logic                    w_wr_mie;
    logic                    w_wr_mtvec;
    logic                    w_wr_mepc;
    logic                    w_wr_mcause;
    logic                    w_wr_mscratch;

    // ---------------------------------------------------------------------
    // Trap / mret qualification
    // ---------------------------------------------------------------------
    assign w_pending  = irqLines & r_mie;
    // An exception in RUN is always taken, regardless of MIE
    assign w_exc_take = (r_state == ST_RUN) && exceptionValid;
    // Interrupts only from RUN, with MIE set, and never over an exception
    assign w_irq_take = (r_state == ST_RUN) && r_mstatus_mie && (|w_pending) && !exceptionValid;
    assign w_trap     = w_exc_take || w_irq_take;
    // An exception alongside mret in HANDLER is a double fault, so mret loses
    assign w_mret     = (r_state == ST_HANDLER) && mretValid && !exceptionValid;

    // Lowest-index pending interrupt: scan downward so the lowest hit is written last
    always_comb begin
        w_irq_index = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_irq_index = w_pending[i] ? 4'(i) : w_irq_index;
        end
    end

    assign w_cause_code = w_irq_take ? w_irq_index : exceptionCause;
    assign w_new_mcause = {w_irq_take, {(DATA_WIDTH-5){1'b0}}, w_cause_code};

    // ---------------------------------------------------------------------
    // Bus write decode
    // ---------------------------------------------------------------------
    assign w_wr_mstatus  = busWriteEnable && (busAddress == ADDR_MSTATUS);
    assign w_wr_mie      = busWriteEnable && (busAddress == ADDR_MIE);
    assign w_wr_mtvec    = busWriteEnable && (busAddress == ADDR_MTVEC);
    assign w_wr_mepc     = busWriteEnable && (busAddress == ADDR_MEPC);
    assign w_wr_mcause   = busWriteEnable && (busAddress == ADDR_MCAUSE);
    assign w_wr_mscratch = busWriteEnable && (busAddress == ADDR_MSCRATCH);

    // ---------------------------------------------------------------------
    // State machine
    // ---------------------------------------------------------------------
    // State register
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; LOCKUP is absorbing until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_trap) begin
                    w_state_next = ST_HANDLER;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HANDLER: begin
                if (exceptionValid) begin
                    w_state_next = ST_LOCKUP;
                end else if (mretValid) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HANDLER;
                end
            end
            ST_LOCKUP: begin
                w_state_next = ST_LOCKUP;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // CSR registers: a bus write to a register overrides the hardware
    // update of that register only.
    // ---------------------------------------------------------------------
    // mstatus.MIE: cleared on trap entry, restored from MPIE on mret
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mstatus_mie <= 1'b0;
        end else if (w_wr_mstatus) begin
            r_mstatus_mie <= busWriteData[3];
        end else if (w_trap) begin
            r_mstatus_mie <= 1'b0;
        end else if (w_mret) begin
            r_mstatus_mie <= r_mstatus_mpie;
        end else begin
            r_mstatus_mie <= r_mstatus_mie;
        end
    end

    // mstatus.MPIE: saves MIE on trap entry, set on mret
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mstatus_mpie <= 1'b0;
        end else if (w_wr_mstatus) begin
            r_mstatus_mpie <= busWriteData[7];
        end else if (w_trap) begin
            r_mstatus_mpie <= r_mstatus_mie;
        end else if (w_mret) begin
            r_mstatus_mpie <= 1'b1;
        end else begin
            r_mstatus_mpie <= r_mstatus_mpie;
        end
    end

    // mie: per-line interrupt enables, software only
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mie <= {NUM_IRQ{1'b0}};
        end else if (w_wr_mie) begin
            r_mie <= busWriteData[NUM_IRQ-1:0];
        end else begin
            r_mie <= r_mie;
        end
    end

    // mtvec: trap base, software only; low two bits are dropped at the output
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mtvec <= RESET_TRAP_VECTOR;
        end else if (w_wr_mtvec) begin
            r_mtvec <= busWriteData;
        end else begin
            r_mtvec <= r_mtvec;
        end
    end

    // mepc: captures the trapping PC
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mepc <= {DATA_WIDTH{1'b0}};
        end else if (w_wr_mepc) begin
            r_mepc <= busWriteData;
        end else if (w_trap) begin
            r_mepc <= pcFromCore;
        end else begin
            r_mepc <= r_mepc;
        end
    end

    // mcause: interrupt flag in the MSB, code in the low bits
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mcause <= {DATA_WIDTH{1'b0}};
        end else if (w_wr_mcause) begin
            r_mcause <= busWriteData;
        end else if (w_trap) begin
            r_mcause <= w_new_mcause;
        end else begin
            r_mcause <= r_mcause;
        end
    end

    // mscratch: plain software scratch register
    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            r_mscratch <= {DATA_WIDTH{1'b0}};
        end else if (w_wr_mscratch) begin
            r_mscratch <= busWriteData;
        end else begin
            r_mscratch <= r_mscratch;
        end
    end

    // ---------------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------------
    // Zero-extended views of the narrow CSRs
    always_comb begin
        w_mstatus_rd              = {DATA_WIDTH{1'b0}};
        w_mstatus_rd[3]           = r_mstatus_mie;
        w_mstatus_rd[7]           = r_mstatus_mpie;
        w_mie_rd                  = {DATA_WIDTH{1'b0}};
        w_mie_rd[NUM_IRQ-1:0]     = r_mie;
        w_mip_rd                  = {DATA_WIDTH{1'b0}};
        w_mip_rd[NUM_IRQ-1:0]     = irqLines;
    end

    // CSR read mux; unmapped address reads zero
    always_comb begin
        busReadData = {DATA_WIDTH{1'b0}};
        case (busAddress)
            ADDR_MSTATUS:  busReadData = w_mstatus_rd;
            ADDR_MIE:      busReadData = w_mie_rd;
            ADDR_MTVEC:    busReadData = r_mtvec;
            ADDR_MEPC:     busReadData = r_mepc;
            ADDR_MCAUSE:   busReadData = r_mcause;
            ADDR_MSCRATCH: busReadData = r_mscratch;
            ADDR_MIP:      busReadData = w_mip_rd;
            default:       busReadData = {DATA_WIDTH{1'b0}};
        endcase
    end

    // ---------------------------------------------------------------------
    // Core-facing outputs
    // ---------------------------------------------------------------------
    assign trapTaken  = w_trap;
    assign trapVector = {r_mtvec[DATA_WIDTH-1:2], 2'b00};
    assign mepcValue  = r_mepc;
    assign inHandler  = (r_state == ST_HANDLER);
    assign lockup     = (r_state == ST_LOCKUP);

endmodule

// File: tb/tb_csr_trap_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_unit
//
// Scoreboard bench for csr_trap_unit. Each stimulus step pushes its expected
// observations (tag + value) onto a queue; observations pop them in order and
// go through check_eq.
// ---------------------------------------------------------------------------
module tb_csr_trap_unit;

    logic        clock;
    logic        resetActiveHigh;
    logic [31:0] pcFromCore;
    logic        exceptionValid;
    logic [3:0]  exceptionCause;
    logic        mretValid;
    logic [3:0]  irqLines;
    logic [2:0]  busAddress;
    logic        busWriteEnable;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;
    logic        trapTaken;
    logic [31:0] trapVector;
    logic [31:0] mepcValue;
    logic        inHandler;
    logic        lockup;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] rd_v;

    csr_trap_unit #(
        .DATA_WIDTH       (32),
        .NUM_IRQ          (4),
        .RESET_TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clock          (clock),
        .resetActiveHigh(resetActiveHigh),
        .pcFromCore     (pcFromCore),
        .exceptionValid (exceptionValid),
        .exceptionCause (exceptionCause),
        .mretValid      (mretValid),
        .irqLines       (irqLines),
        .busAddress     (busAddress),
        .busWriteEnable (busWriteEnable),
        .busWriteData   (busWriteData),
        .busReadData    (busReadData),
        .trapTaken      (trapTaken),
        .trapVector     (trapVector),
        .mepcValue      (mepcValue),
        .inHandler      (inHandler),
        .lockup         (lockup)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got 0x%08h expected none", act);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, act, e);
        end
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        busWriteEnable = 1'b0;
        busAddress     = a;
        #1;
        d = busReadData;
    endtask

    task automatic obs_csr(input logic [2:0] a);
        logic [31:0] v;
        rd(a, v);
        pop_cmp(v);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        busAddress     = a;
        busWriteData   = d;
        busWriteEnable = 1'b1;
        tick();
        busWriteEnable = 1'b0;
    endtask

    task automatic obs_bit(input logic b);
        pop_cmp({31'd0, b});
    endtask

    initial begin
        resetActiveHigh = 1'b1;
        pcFromCore      = 32'h0;
        exceptionValid  = 1'b0;
        exceptionCause  = 4'd0;
        mretValid       = 1'b0;
        irqLines        = 4'h0;
        busAddress      = 3'd0;
        busWriteEnable  = 1'b0;
        busWriteData    = 32'h0;
        tick();
        tick();
        resetActiveHigh = 1'b0;

        // ---- reset state ----
        push_exp("rst_mtvec", 32'h100);
        push_exp("rst_mstatus", 32'h0);
        push_exp("rst_mie", 32'h0);
        push_exp("rst_mepc", 32'h0);
        push_exp("rst_mcause", 32'h0);
        obs_csr(3'd2); obs_csr(3'd0); obs_csr(3'd1); obs_csr(3'd3); obs_csr(3'd4);
        tick();
        push_exp("rst_mscratch", 32'h0);
        push_exp("rst_addr7", 32'h0);
        push_exp("rst_trapTaken", 32'h0);
        push_exp("rst_inHandler", 32'h0);
        push_exp("rst_lockup", 32'h0);
        obs_csr(3'd5); obs_csr(3'd7);
        obs_bit(trapTaken); obs_bit(inHandler); obs_bit(lockup);
        tick();

        // ---- exception with MIE=0 ----
        push_exp("exc_trapTaken", 32'h1);
        push_exp("exc_trapVector", 32'h100);
        exceptionValid = 1'b1; exceptionCause = 4'd2; pcFromCore = 32'h40;
        #1;
        obs_bit(trapTaken); pop_cmp(trapVector);
        tick();
        exceptionValid = 1'b0;
        push_exp("exc_mepc", 32'h40);
        push_exp("exc_mcause", 32'h2);
        push_exp("exc_mstatus", 32'h0);
        push_exp("exc_inHandler", 32'h1);
        push_exp("exc_mepcValue", 32'h40);
        obs_csr(3'd3); obs_csr(3'd4); obs_csr(3'd0);
        obs_bit(inHandler); pop_cmp(mepcValue);
        mretValid = 1'b1;
        tick();
        mretValid = 1'b0;
        push_exp("mret1_mstatus", 32'h80);
        push_exp("mret1_inHandler", 32'h0);
        obs_csr(3'd0); obs_bit(inHandler);

        // ---- interrupt, lowest pending index wins ----
        wr(3'd0, 32'h8);
        wr(3'd1, 32'hF);
        pcFromCore = 32'h1234;
        irqLines   = 4'b1100;
        push_exp("irq_trapTaken", 32'h1);
        #1;
        obs_bit(trapTaken);
        tick();
        irqLines = 4'b0000;
        push_exp("irq_mcause", 32'h8000_0002);
        push_exp("irq_mstatus", 32'h80);
        push_exp("irq_mepc", 32'h1234);
        push_exp("irq_inHandler", 32'h1);
        obs_csr(3'd4); obs_csr(3'd0); obs_csr(3'd3); obs_bit(inHandler);

        // software sets MIE inside handler: still no nested interrupt
        wr(3'd0, 32'h88);
        irqLines = 4'b0001;
        push_exp("nest_trapTaken", 32'h0);
        #1;
        obs_bit(trapTaken);
        tick();
        irqLines = 4'b0000;
        push_exp("nest_inHandler", 32'h1);
        push_exp("nest_mcause", 32'h8000_0002);
        obs_bit(inHandler); obs_csr(3'd4);
        mretValid = 1'b1;
        tick();
        mretValid = 1'b0;
        push_exp("mret2_mstatus", 32'h88);
        push_exp("mret2_inHandler", 32'h0);
        obs_csr(3'd0); obs_bit(inHandler);

        // second pattern: lines 1 and 3 pending -> index 1
        irqLines = 4'b1010;
        push_exp("irq1_trapTaken", 32'h1);
        #1;
        obs_bit(trapTaken);
        tick();
        irqLines = 4'b0000;
        push_exp("irq1_mcause", 32'h8000_0001);
        obs_csr(3'd4);
        mretValid = 1'b1;
        tick();
        mretValid = 1'b0;
        push_exp("mret3_mstatus", 32'h88);
        obs_csr(3'd0);

        // ---- bus write to mepc during an exception ----
        busAddress     = 3'd3;
        busWriteData   = 32'h200;
        busWriteEnable = 1'b1;
        exceptionValid = 1'b1; exceptionCause = 4'd5; pcFromCore = 32'h40;
        push_exp("col_trapTaken", 32'h1);
        #1;
        obs_bit(trapTaken);
        tick();
        busWriteEnable = 1'b0;
        exceptionValid = 1'b0;
        push_exp("col_mepc", 32'h200);
        push_exp("col_mcause", 32'h5);
        push_exp("col_mstatus", 32'h80);
        push_exp("col_inHandler", 32'h1);
        obs_csr(3'd3); obs_csr(3'd4); obs_csr(3'd0); obs_bit(inHandler);

        // ---- double fault -> lockup ----
        exceptionValid = 1'b1; exceptionCause = 4'd7; pcFromCore = 32'h999;
        push_exp("df_trapTaken", 32'h0);
        #1;
        obs_bit(trapTaken);
        tick();
        exceptionValid = 1'b0;
        push_exp("df_lockup", 32'h1);
        push_exp("df_inHandler", 32'h0);
        push_exp("df_mcause", 32'h5);
        push_exp("df_mepc", 32'h200);
        obs_bit(lockup); obs_bit(inHandler); obs_csr(3'd4); obs_csr(3'd3);

        // trap and mret inputs ignored in lockup
        exceptionValid = 1'b1; exceptionCause = 4'd9; mretValid = 1'b1;
        push_exp("lk_trapTaken", 32'h0);
        #1;
        obs_bit(trapTaken);
        tick();
        exceptionValid = 1'b0; mretValid = 1'b0;
        push_exp("lk_lockup", 32'h1);
        push_exp("lk_mcause", 32'h5);
        push_exp("lk_mstatus", 32'h80);
        obs_bit(lockup); obs_csr(3'd4); obs_csr(3'd0);

        // bus still works in lockup
        wr(3'd5, 32'hDEAD_BEEF);
        push_exp("lk_mscratch", 32'hDEAD_BEEF);
        push_exp("lk_lockup2", 32'h1);
        obs_csr(3'd5); obs_bit(lockup);

        // async reset clears lockup
        resetActiveHigh = 1'b1;
        #1;
        push_exp("rst2_lockup", 32'h0);
        push_exp("rst2_inHandler", 32'h0);
        obs_bit(lockup); obs_bit(inHandler);
        tick();
        resetActiveHigh = 1'b0;
        push_exp("rst2_mscratch", 32'h0);
        push_exp("rst2_mtvec", 32'h100);
        obs_csr(3'd5); obs_csr(3'd2);

        // ---- MIE=0 masks interrupts; mip is read-only ----
        wr(3'd1, 32'hF);
        irqLines = 4'hF;
        push_exp("mask_trapTaken", 32'h0);
        push_exp("mask_mip", 32'hF);
        #1;
        obs_bit(trapTaken);
        obs_csr(3'd6);
        wr(3'd6, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        push_exp("mask_mip_ro", 32'hF);
        push_exp("mask_inHandler", 32'h0);
        push_exp("mask_addr7", 32'h0);
        obs_csr(3'd6); obs_bit(inHandler); obs_csr(3'd7);

        // ---- exception beats a simultaneously eligible interrupt ----
        busAddress     = 3'd0;
        busWriteData   = 32'h8;
        busWriteEnable = 1'b1;
        tick();
        busWriteEnable = 1'b0;
        exceptionValid = 1'b1; exceptionCause = 4'd3; pcFromCore = 32'h80;
        push_exp("prio_trapTaken", 32'h1);
        #1;
        obs_bit(trapTaken);
        tick();
        exceptionValid = 1'b0;
        irqLines       = 4'h0;
        push_exp("prio_mcause", 32'h3);
        push_exp("prio_mepc", 32'h80);
        obs_csr(3'd4); obs_csr(3'd3);

        // ---- mtvec low bits dropped from trapVector ----
        wr(3'd2, 32'h2003);
        push_exp("mtvec_vector", 32'h2000);
        pop_cmp(trapVector);

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
